tsn_dma_arb: RTL

Four-channel round-robin DMA arbiter directly downstream of the DGCL. It takes the per-channel DMA request/response and write/read streams (channels A–D) and grants exactly one channel at a time to a single shared memory port. It muxes write beats out to that port and read beats back to the granted channel, and reports per-grant beat counts for debug.

---
 rtl/tsn_dma_arb_if.sv | 37 +++
 rtl/tsn_dma_arb.sv | 108 ++++++++++
 2 files changed

// File: rtl/tsn_dma_arb_if.sv
// tsn_dma_arb_if: DMA channel and shared memory port bundle.
// slave = arbiter view, master = channel/memory environment view.
interface tsn_dma_arb_if #(
  parameter int DATA_W = 128
);
  logic [3:0]          DMA_REQ;
  logic [3:0]          DMA_RESP;
  logic [3:0]          DMA_WRITE_VALID;
  logic [4*DATA_W-1:0] DMA_WRITE_DATA;
  logic [3:0]          DMA_WRITE_READY;
  logic [3:0]          DMA_READ_VALID;
  logic [DATA_W-1:0]   DMA_READ_DATA;
  logic [3:0]          DMA_READ_READY;
  logic                MEM_REQ;
  logic                MEM_WVALID;
  logic [DATA_W-1:0]   MEM_WDATA;
  logic                MEM_WREADY;
  logic                MEM_RVALID;
  logic [DATA_W-1:0]   MEM_RDATA;
  logic                MEM_RREADY;

  modport slave (
    input  DMA_REQ, DMA_WRITE_VALID, DMA_WRITE_DATA,
    input  DMA_READ_READY, MEM_WREADY, MEM_RVALID, MEM_RDATA,
    output DMA_RESP, DMA_WRITE_READY, DMA_READ_VALID,
    output DMA_READ_DATA, MEM_REQ, MEM_WVALID, MEM_WDATA,
    output MEM_RREADY
  );

  modport master (
    output DMA_REQ, DMA_WRITE_VALID, DMA_WRITE_DATA,
    output DMA_READ_READY, MEM_WREADY, MEM_RVALID, MEM_RDATA,
    input  DMA_RESP, DMA_WRITE_READY, DMA_READ_VALID,
    input  DMA_READ_DATA, MEM_REQ, MEM_WVALID, MEM_WDATA,
    input  MEM_RREADY
  );
endinterface

// File: rtl/tsn_dma_arb.sv
// tsn_dma_arb: 4-channel round-robin DMA arbiter onto one memory port.
// Combinational data muxes, registered grant, per-grant beat counters.
module tsn_dma_arb #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic             fpu_clk,
  input  logic             reset,
  tsn_dma_arb_if.slave     bus,
  output logic [1:0]       GNT_ID,
  output logic [CNT_W-1:0] WBEATS,
  output logic [CNT_W-1:0] RBEATS
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       owner;
  logic [1:0]       last;
  logic [1:0]       win;
  logic             win_found;
  logic             any_req;
  logic             take;
  logic             wfire;
  logic             rfire;
  logic [CNT_W-1:0] wbeats;
  logic [CNT_W-1:0] rbeats;

  assign any_req = |bus.DMA_REQ;
  assign take    = (state != GRANT) && any_req;
  assign wfire   = bus.MEM_WVALID & bus.MEM_WREADY;
  assign rfire   = bus.MEM_RVALID & bus.MEM_RREADY;

  // Search starts just past the last winner, so it ends up lowest.
  always_comb begin
    win       = last;
    win_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!win_found && bus.DMA_REQ[last + 2'(i)]) begin
        win       = last + 2'(i);
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge fpu_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   if (!bus.DMA_REQ[owner]) state_nxt = RELEASE;
      RELEASE: state_nxt = any_req ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge fpu_clk or negedge reset) begin
    if (!reset) begin
      owner  <= 2'd0;
      last   <= 2'd3;
      wbeats <= '0;
      rbeats <= '0;
    end else if (take) begin
      owner  <= win;
      last   <= win;
      wbeats <= '0;
      rbeats <= '0;
    end else if (state == GRANT) begin
      if (wfire && wbeats != '1) wbeats <= wbeats + CNT_W'(1);
      if (rfire && rbeats != '1) rbeats <= rbeats + CNT_W'(1);
    end
  end

  always_comb begin
    bus.DMA_RESP        = 4'b0000;
    bus.MEM_REQ         = 1'b0;
    bus.MEM_WVALID      = 1'b0;
    bus.MEM_WDATA       = '0;
    bus.DMA_WRITE_READY = 4'b0000;
    bus.DMA_READ_VALID  = 4'b0000;
    bus.DMA_READ_DATA   = bus.MEM_RDATA;
    bus.MEM_RREADY      = 1'b0;
    if (state == GRANT) begin
      bus.DMA_RESP[owner]        = 1'b1;
      bus.MEM_REQ                = 1'b1;
      bus.MEM_WVALID             = bus.DMA_WRITE_VALID[owner];
      bus.MEM_WDATA              =
        bus.DMA_WRITE_DATA[int'(owner)*DATA_W +: DATA_W];
      bus.DMA_WRITE_READY[owner] = bus.MEM_WREADY;
      bus.DMA_READ_VALID[owner]  = bus.MEM_RVALID;
      bus.MEM_RREADY             = bus.DMA_READ_READY[owner];
    end
  end

  assign GNT_ID = owner;
  assign WBEATS = wbeats;
  assign RBEATS = rbeats;

endmodule
